// File: rtl/tdm_select_seq.sv
// -----------------------------------------------------------------------------
// tdm_select_seq
//   Time-division select sequencer. Rotates a registered channel select across
//   CHANNELS packed input words, spending DWELL cycles on each, and registers
//   the selected word together with a valid flag and a frame marker.
//
//   Optional feature: define TDM_SKIP_MASK_EN to add skip_mask_i, which removes
//   masked channels from the rotation. Without it every channel is active.
//
//   Ports
//     clk_i          system clock, rising edge
//     rst_i          synchronous active-high reset
//     en_i           run enable (level)
//     din_i          packed channel words, channel k at [k*WIDTH +: WIDTH]
//     skip_mask_i    bit k=1 skips channel k (TDM_SKIP_MASK_EN only)
//     sel_o          current select, also drives the external mux
//     y_o            registered selected word
//     y_valid_o      y_o holds a sample taken while running
//     frame_start_o  y_o is the first sample of a frame
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | stopped, sel=0, y_o held, y_valid_o/frame_start_o low
//   ST_RUN  | sampling din at sel every cycle, advancing on dwell end
// -----------------------------------------------------------------------------
module tdm_select_seq #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 1,
    localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic [CHANNELS*WIDTH-1:0] din_i,
`ifdef TDM_SKIP_MASK_EN
    input  logic [CHANNELS-1:0]       skip_mask_i,
`endif
    output logic [SELW-1:0]           sel_o,
    output logic [WIDTH-1:0]          y_o,
    output logic                      y_valid_o,
    output logic                      frame_start_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q;
    logic [SELW-1:0]   sel_q;
    logic [7:0]        cnt_q;
    logic [WIDTH-1:0]  y_q;
    logic              y_valid_q;
    logic              frame_start_q;

    logic [CHANNELS-1:0] active;
    logic                any_active;
    logic [SELW-1:0]     first_sel_d;
    logic [SELW-1:0]     next_sel_d;
    logic                next_found;
    logic                last_dwell;
    logic [WIDTH-1:0]    sel_word;

`ifdef TDM_SKIP_MASK_EN
    assign active = ~skip_mask_i;
`else
    assign active = '1;
`endif

    assign any_active = |active;
    assign last_dwell = (cnt_q == 8'(DWELL - 1));
    assign sel_word   = din_i[int'(sel_q)*WIDTH +: WIDTH];

    // Lowest active index; scanning downward lets the lowest hit win.
    always_comb begin
        first_sel_d = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (active[k]) first_sel_d = SELW'(k);
        end
    end

    // Next active index after sel_q in circular order. k=CHANNELS lands back
    // on sel_q itself, so a lone active channel selects itself again.
    always_comb begin
        next_sel_d = sel_q;
        next_found = 1'b0;
        for (int k = 1; k <= CHANNELS; k++) begin
            if (!next_found && active[(int'(sel_q) + k) % CHANNELS]) begin
                next_sel_d = SELW'((int'(sel_q) + k) % CHANNELS);
                next_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            cnt_q         <= '0;
            y_q           <= '0;
            y_valid_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    y_valid_q     <= 1'b0;
                    frame_start_q <= 1'b0;
                    // Entry is refused while every channel is masked off.
                    if (en_i && any_active) begin
                        state_q <= ST_RUN;
                        sel_q   <= first_sel_d;
                        cnt_q   <= '0;
                    end
                end
                ST_RUN: begin
                    if (!en_i || !any_active) begin
                        // Abandon the current dwell; y_q keeps the last sample.
                        state_q       <= ST_IDLE;
                        sel_q         <= '0;
                        cnt_q         <= '0;
                        y_valid_q     <= 1'b0;
                        frame_start_q <= 1'b0;
                    end else begin
                        y_q           <= sel_word;
                        y_valid_q     <= 1'b1;
                        frame_start_q <= (sel_q == first_sel_d) && (cnt_q == 8'd0);
                        if (last_dwell) begin
                            cnt_q <= '0;
                            sel_q <= next_sel_d;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    sel_q   <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign sel_o         = sel_q;
    assign y_o           = y_q;
    assign y_valid_o     = y_valid_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_tdm_select_seq.sv
module tb_tdm_select_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        en1;
    logic [31:0] din;
    logic [3:0]  skip_mask;

    logic [1:0]  sel,  sel1;
    logic [7:0]  y,    y1;
    logic        yv,   yv1;
    logic        fs,   fs1;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {
        logic [7:0] y;
        logic       v;
        logic       fs;
        logic [1:0] sel;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp1_q[$];

    always #5 clk = ~clk;

    tdm_select_seq #(.WIDTH(8), .CHANNELS(4), .DWELL(2)) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .din_i         (din),
`ifdef TDM_SKIP_MASK_EN
        .skip_mask_i   (skip_mask),
`endif
        .sel_o         (sel),
        .y_o           (y),
        .y_valid_o     (yv),
        .frame_start_o (fs)
    );

    tdm_select_seq #(.WIDTH(8), .CHANNELS(4), .DWELL(1)) u_dut1 (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en1),
        .din_i         (din),
`ifdef TDM_SKIP_MASK_EN
        .skip_mask_i   (4'b0000),
`endif
        .sel_o         (sel1),
        .y_o           (y1),
        .y_valid_o     (yv1),
        .frame_start_o (fs1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] word(input int ch);
        logic [31:0] d;
        d = din;
        return d[ch*8 +: 8];
    endfunction

    task automatic push_exp(input bit to1, input logic [7:0] ey, input logic ev,
                            input logic efs, input logic [1:0] esel);
        exp_t e;
        e.y = ey; e.v = ev; e.fs = efs; e.sel = esel;
        if (to1) exp1_q.push_back(e);
        else     exp_q.push_back(e);
    endtask

    // Expected outputs for running samples first_i..last_i of an unmasked
    // 4-channel rotation: sample i comes from channel (i/dw)%4 and the select
    // after that edge already points at the channel of sample i+1.
    task automatic push_run(input bit to1, input int first_i, input int last_i, input int dw);
        for (int i = first_i; i <= last_i; i++) begin
            push_exp(to1, word((i / dw) % 4), 1'b1, (i % (dw * 4)) == 0,
                     2'(((i + 1) / dw) % 4));
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("y",           32'(y),   32'(e.y));
            check("y_valid",     32'(yv),  32'(e.v));
            check("frame_start", 32'(fs),  32'(e.fs));
            check("sel",         32'(sel), 32'(e.sel));
        end
        if (exp1_q.size() > 0) begin
            e = exp1_q.pop_front();
            check("d1_y",           32'(y1),   32'(e.y));
            check("d1_y_valid",     32'(yv1),  32'(e.v));
            check("d1_frame_start", 32'(fs1),  32'(e.fs));
            check("d1_sel",         32'(sel1), 32'(e.sel));
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; en1 = 1'b0; skip_mask = 4'b0000;
        din = 32'h44332211;

        // reset then idle
        repeat (3) push_exp(0, 8'h00, 0, 0, 2'd0);
        ticks(3);
        rst = 1'b0;
        repeat (5) push_exp(0, 8'h00, 0, 0, 2'd0);
        ticks(5);

        // rotation: entry edge, then samples up to the second 22 dwell cycle
        en = 1'b1;
        push_exp(0, 8'h00, 0, 0, 2'd0);
        push_run(0, 0, 18, 2);
        ticks(20);

        // en drop mid-dwell, y holds the last sample
        en = 1'b0;
        repeat (2) push_exp(0, 8'h22, 0, 0, 2'd0);
        ticks(2);

        // restart from channel 0 with frame_start
        en = 1'b1;
        push_exp(0, 8'h22, 0, 0, 2'd0);
        push_run(0, 0, 3, 2);
        ticks(5);

        // reset while sel=2
        rst = 1'b1;
        push_exp(0, 8'h00, 0, 0, 2'd0);
        tick();
        rst = 1'b0;
        push_exp(0, 8'h00, 0, 0, 2'd0);
        push_run(0, 0, 1, 2);
        ticks(3);

        // new channel data is picked up on the sampling edge
        din = 32'hd4c3b2a1;
        push_run(0, 2, 9, 2);
        ticks(8);
        en = 1'b0;
        push_exp(0, 8'ha1, 0, 0, 2'd0);
        tick();

        // DWELL=1 instance: 3 -> 0 wrap with no gap
        din = 32'h44332211;
        en1 = 1'b1;
        push_exp(1, 8'h00, 0, 0, 2'd0);
        push_run(1, 0, 8, 1);
        ticks(10);
        en1 = 1'b0;

`ifdef TDM_SKIP_MASK_EN
        rst = 1'b1;
        push_exp(0, 8'h00, 0, 0, 2'd0);
        tick();
        rst = 1'b0;
        skip_mask = 4'b0101;
        en = 1'b1;
        push_exp(0, 8'h00, 0, 0, 2'd1);
        push_exp(0, 8'h22, 1, 1, 2'd1);
        push_exp(0, 8'h22, 1, 0, 2'd3);
        push_exp(0, 8'h44, 1, 0, 2'd3);
        push_exp(0, 8'h44, 1, 0, 2'd1);
        push_exp(0, 8'h22, 1, 1, 2'd1);
        ticks(6);
        en = 1'b0;
        push_exp(0, 8'h22, 0, 0, 2'd0);
        tick();
        skip_mask = 4'b1111;
        en = 1'b1;
        repeat (3) push_exp(0, 8'h22, 0, 0, 2'd0);
        ticks(3);
        en = 1'b0;
        skip_mask = 4'b0000;
`endif

        check("sb_drain", 32'(exp_q.size() + exp1_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tdm_select_seq.md
# tdm_select_seq

Time-division select sequencer that sits directly upstream of the two_one / N:1 mux stage. It owns the select lines, rotates them across CHANNELS input words with a programmable dwell per channel, and registers the selected word with a valid flag and a frame marker. Downstream logic receives one serialized stream instead of free-running mux outputs.

## Interface
- WIDTH, 8: bits per channel word.
- CHANNELS, 4: number of input channels, 2..16.
- DWELL, 1: cycles spent on each channel, 1..255.
- SELW, derived: clog2(CHANNELS), minimum 1. Not overridable.

- clk  in  1  system clock, rising edge.
- rst  in  1  reset. Synchronous and active-high.
- en  in  1  run enable; level-sensitive.
- din  in  CHANNELS*WIDTH  packed channel words; channel k occupies din[k*WIDTH +: WIDTH].
- skip_mask  in  CHANNELS  bit k=1 skips channel k. Present only with TDM_SKIP_MASK_EN.
- sel  out  SELW  current select, also drives the external mux select.
- y  out  WIDTH  registered selected word.
- y_valid  out  1  y holds a sample taken while running.
- frame_start  out  1  y is the first sample of a frame.

## Operation
- States: IDLE, RUN. A dwell counter cnt counts 0..DWELL-1.
- Reset (rst=1 at an edge, overriding everything):
  - state=IDLE, sel=0, cnt=0
  - y=0, y_valid=0, frame_start=0
- IDLE:
  - Outputs y_valid=0 and frame_start=0. y holds its last value.
  - en=1 -> RUN. sel=first active channel (channel 0 without the mask), cnt=0.
- RUN, every cycle:
  - y <= din slice at sel, y_valid <= 1.
  - frame_start <= 1 iff sel == first active channel and cnt == 0.
- RUN, advance:
  - cnt == DWELL-1 -> cnt <= 0 and sel <= next active channel in circular order.
  - CHANNELS-1 wraps to 0. Otherwise cnt <= cnt+1.
- en=0 in RUN:
  - -> IDLE at that edge. sel <= 0, cnt <= 0, y_valid <= 0, frame_start <= 0.
  - No drain: the in-progress dwell is abandoned.
- rst mid-RUN: identical to reset. No partial frame completes.
- Simultaneous rst and en: rst wins.

## Timing
- Latency is 1 cycle: y/y_valid at edge n+1 reflect sel and din at edge n.
- The first valid sample appears 2 edges after en rises: edge 1 enters RUN, edge 2 registers y.
- Frame period is DWELL × (number of active channels) cycles.
- frame_start is high for exactly one cycle per frame, aligned with the first sample of the first channel.
- din is not held internally. The sampled value is whatever is present on the sampling edge.
- sel changes only on dwell boundaries, IDLE->RUN entry, en drop, or reset. It is glitch-free (registered).

## Configuration
- TDM_SKIP_MASK_EN defined:
  - skip_mask port exists. The next active channel is the next unmasked index.
  - The mask is sampled only at advance and at IDLE->RUN entry. Masking the current channel mid-dwell lets that dwell complete.
  - If all bits are 1, entry from IDLE is blocked (stay IDLE). In RUN, the next edge goes to IDLE with y_valid <= 0.
  - "First active channel" is the lowest unmasked index at the time of evaluation.
- Undefined: there is no skip_mask port. All channels are active and the first active channel is 0.

## Test plan
Directed scenarios use WIDTH=8, CHANNELS=4, DWELL=2, din={8'h44,8'h33,8'h22,8'h11}.

- Reset/idle: rst=1 for 3 cycles, then en=0 for 5 cycles -> sel=0, y=8'h00, y_valid=0, frame_start=0 throughout.
- Rotation: en=1 held -> after the 2-edge startup, y sequence is 11,11,22,22,33,33,44,44,11.
  - y_valid stays 1.
  - frame_start is 1 only on the first 11 of each 8-cycle frame.
- en drop: deassert en during the second 22 dwell cycle -> next edge y_valid=0, sel=0. Re-raising en restarts from channel 0 with frame_start.
- Reset mid-run: rst=1 while sel=2 -> next edge sel=0, y=0, y_valid=0. Operation resumes from IDLE.
- DWELL=1 wrap (param override): y cycles 11,22,33,44,11. sel goes 3->0 with no gap.
- Mask (TDM_SKIP_MASK_EN):
  - skip_mask=4'b0101 -> y sequence is 22,22,44,44,22, with frame_start on the first 22.
  - skip_mask=4'b1111 with en=1 -> stays IDLE, y_valid=0.
